// File: rtl/dec_7seg_pkg.sv
// Shared constants and helpers for the two-digit 7-segment decoder.
// Patterns are active-high, bit order {g,f,e,d,c,b,a}.
package dec_7seg_pkg;

    localparam int SEG_W = 7;

    typedef logic [SEG_W-1:0] seg_t;
    typedef logic [3:0]       bcd_t;

    localparam seg_t SEG_0     = 7'h3F;
    localparam seg_t SEG_1     = 7'h06;
    localparam seg_t SEG_2     = 7'h5B;
    localparam seg_t SEG_3     = 7'h4F;
    localparam seg_t SEG_4     = 7'h66;
    localparam seg_t SEG_5     = 7'h6D;
    localparam seg_t SEG_6     = 7'h7D;
    localparam seg_t SEG_7     = 7'h07;
    localparam seg_t SEG_8     = 7'h7F;
    localparam seg_t SEG_9     = 7'h6F;
    localparam seg_t SEG_BLANK = 7'h00;

    localparam bcd_t TEN = 4'd10;

    // Non-decimal codes map to blank so a bad digit never shows garbage.
    function automatic seg_t seg_encode(input bcd_t bcd);
        seg_t s;
        case (bcd)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Apply display polarity to an active-high pattern.
    function automatic seg_t seg_pol(input seg_t s, input bit active_low);
        return active_low ? ~s : s;
    endfunction

endpackage

// File: rtl/seg7_digit.sv
// Combinational BCD-to-segment decoder for one display digit.
// Output already carries the display polarity.
module seg7_digit
    import dec_7seg_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Encode then invert for common-anode parts.
    always_comb begin
        seg = seg_pol(seg_encode(bcd), ACTIVE_LOW);
    end

endmodule

// File: rtl/dec_7seg.sv
// Binary 0..15 to two registered 7-segment digits (Q2 tens, Q1 ones).
// Outputs are flops only; reset blanks both digits asynchronously.
module dec_7seg
    import dec_7seg_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b0,
    parameter bit BLANK_LZ   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] D,
    output logic [6:0] Q1,
    output logic [6:0] Q2
);

    localparam seg_t BLANK = seg_pol(SEG_BLANK, ACTIVE_LOW);

    logic       tens;
    logic [3:0] ones_bcd;
    logic [3:0] tens_bcd;
    seg_t       ones_seg;
    seg_t       tens_seg;
    seg_t       q1_next;
    seg_t       q2_next;

    // Split into tens (0/1) and ones (0..9).
    always_comb begin
        tens     = (D >= TEN);
        ones_bcd = tens ? (D - TEN) : D;
        tens_bcd = {3'b000, tens};
    end

    seg7_digit #(
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_ones (
        .bcd (ones_bcd),
        .seg (ones_seg)
    );

    seg7_digit #(
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_tens (
        .bcd (tens_bcd),
        .seg (tens_seg)
    );

    // Optional leading-zero blanking on the tens digit only.
    always_comb begin
        q1_next = ones_seg;
        q2_next = tens_seg;
        if (BLANK_LZ && !tens) begin
            q2_next = BLANK;
        end
    end

    // Output registers; blank while in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Q1 <= BLANK;
            Q2 <= BLANK;
        end else begin
            Q1 <= q1_next;
            Q2 <= q2_next;
        end
    end

endmodule

// File: tb/tb_dec_7seg.sv
// Directed bench for dec_7seg: default, active-low and
// leading-zero-blank instances driven from one stimulus.
module tb_dec_7seg;

    typedef struct {
        logic [3:0] d;
        logic [6:0] q1;
        logic [6:0] q2;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [3:0] d;
    logic [6:0] q1_def, q2_def;
    logic [6:0] q1_al,  q2_al;
    logic [6:0] q1_lz,  q2_lz;

    int errors;
    int checks;

    vec_t vecs [16];

    dec_7seg u_def (
        .clk (clk),
        .rst (rst),
        .D   (d),
        .Q1  (q1_def),
        .Q2  (q2_def)
    );

    dec_7seg #(
        .ACTIVE_LOW (1'b1)
    ) u_al (
        .clk (clk),
        .rst (rst),
        .D   (d),
        .Q1  (q1_al),
        .Q2  (q2_al)
    );

    dec_7seg #(
        .BLANK_LZ (1'b1)
    ) u_lz (
        .clk (clk),
        .rst (rst),
        .D   (d),
        .Q1  (q1_lz),
        .Q2  (q2_lz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name,
                       input logic [6:0] act,
                       input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic [3:0] v);
        @(negedge clk);
        d = v;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag,
                           input logic [6:0] e1,
                           input logic [6:0] e2,
                           input logic [6:0] l2);
        chk({tag, " def Q1"}, q1_def, e1);
        chk({tag, " def Q2"}, q2_def, e2);
        chk({tag, " al Q1"},  q1_al,  ~e1);
        chk({tag, " al Q2"},  q2_al,  ~e2);
        chk({tag, " lz Q1"},  q1_lz,  e1);
        chk({tag, " lz Q2"},  q2_lz,  l2);
    endtask

    task automatic chk_blank(input string tag);
        chk({tag, " def Q1"}, q1_def, 7'h00);
        chk({tag, " def Q2"}, q2_def, 7'h00);
        chk({tag, " al Q1"},  q1_al,  7'h7F);
        chk({tag, " al Q2"},  q2_al,  7'h7F);
        chk({tag, " lz Q1"},  q1_lz,  7'h00);
        chk({tag, " lz Q2"},  q2_lz,  7'h00);
    endtask

    initial begin
        errors = 0;
        checks = 0;

        vecs[0]  = '{4'd0,  7'h3F, 7'h3F};
        vecs[1]  = '{4'd1,  7'h06, 7'h3F};
        vecs[2]  = '{4'd2,  7'h5B, 7'h3F};
        vecs[3]  = '{4'd3,  7'h4F, 7'h3F};
        vecs[4]  = '{4'd4,  7'h66, 7'h3F};
        vecs[5]  = '{4'd5,  7'h6D, 7'h3F};
        vecs[6]  = '{4'd6,  7'h7D, 7'h3F};
        vecs[7]  = '{4'd7,  7'h07, 7'h3F};
        vecs[8]  = '{4'd8,  7'h7F, 7'h3F};
        vecs[9]  = '{4'd9,  7'h6F, 7'h3F};
        vecs[10] = '{4'd10, 7'h3F, 7'h06};
        vecs[11] = '{4'd11, 7'h06, 7'h06};
        vecs[12] = '{4'd12, 7'h5B, 7'h06};
        vecs[13] = '{4'd13, 7'h4F, 7'h06};
        vecs[14] = '{4'd14, 7'h66, 7'h06};
        vecs[15] = '{4'd15, 7'h6D, 7'h06};

        rst = 1'b0;
        d   = 4'd7;
        step(4'd7);
        step(4'd7);
        chk_all("pre d7", 7'h07, 7'h3F, 7'h00);

        // Async reset with no clock edge in between.
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_blank("rst async");
        @(posedge clk);
        #1;
        chk_blank("rst held");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_blank("rst released");
        @(posedge clk);
        #1;
        chk_all("post rst d7", 7'h07, 7'h3F, 7'h00);

        // Sweep, one value per cycle.
        for (int i = 0; i < 16; i++) begin
            step(vecs[i].d);
            chk_all($sformatf("sweep d%0d", vecs[i].d),
                    vecs[i].q1, vecs[i].q2,
                    (vecs[i].d < 4'd10) ? 7'h00 : vecs[i].q2);
        end

        // Back-to-back changes.
        step(4'd3);
        chk_all("b2b d3", 7'h4F, 7'h3F, 7'h00);
        step(4'd14);
        chk_all("b2b d14", 7'h66, 7'h06, 7'h06);
        step(4'd1);
        chk_all("b2b d1", 7'h06, 7'h3F, 7'h00);

        // Spot checks from hand calculation.
        step(4'd8);
        chk("al d8 Q1", q1_al, 7'h00);
        chk("al d8 Q2", q2_al, 7'h40);
        step(4'd0);
        chk("lz d0 Q1", q1_lz, 7'h3F);
        chk("lz d0 Q2", q2_lz, 7'h00);

        // Mid-stream reset pulse while D=11.
        step(4'd11);
        chk_all("mid d11", 7'h06, 7'h06, 7'h06);
        #2;
        rst = 1'b1;
        #1;
        chk_blank("mid rst");
        @(posedge clk);
        #1;
        chk_blank("mid rst edge");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_all("mid resume", 7'h06, 7'h06, 7'h06);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
